// File: rtl/opcode_pkg.sv
// Operation and opcode types shared by the opcode issuer and its FIFO.
// Holds the 3-bit operation codes, the 6-bit one-hot opcode words and the encoder.
package opcode_pkg;

  typedef logic [2:0] operation_t;
  typedef logic [5:0] opcode_t;

  localparam int unsigned OPC_W = 6;

  localparam operation_t OP_NOP     = 3'b000;
  localparam operation_t OP_ADD     = 3'b001;
  localparam operation_t OP_SUB     = 3'b010;
  localparam operation_t OP_AND     = 3'b011;
  localparam operation_t OP_OR      = 3'b100;
  localparam operation_t OP_XOR     = 3'b101;
  localparam operation_t OP_SHL     = 3'b110;
  localparam operation_t OP_ILLEGAL = 3'b111;

  localparam opcode_t OPC_NOP = 6'b000000;
  localparam opcode_t OPC_ADD = 6'b100000;
  localparam opcode_t OPC_SUB = 6'b010000;
  localparam opcode_t OPC_AND = 6'b001000;
  localparam opcode_t OPC_OR  = 6'b000100;
  localparam opcode_t OPC_XOR = 6'b000010;
  localparam opcode_t OPC_SHL = 6'b000001;

  // Illegal codes map to the all-zero word; callers must filter them before pushing.
  function automatic opcode_t encode(input operation_t op);
    opcode_t opc;
    case (op)
      OP_NOP:  opc = OPC_NOP;
      OP_ADD:  opc = OPC_ADD;
      OP_SUB:  opc = OPC_SUB;
      OP_AND:  opc = OPC_AND;
      OP_OR:   opc = OPC_OR;
      OP_XOR:  opc = OPC_XOR;
      OP_SHL:  opc = OPC_SHL;
      default: opc = OPC_NOP;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// Generic DEPTH x 6 synchronous FIFO with registered level and full/empty flags.
// Push while full and pop while empty are ignored; no pass-through when empty.
module opcode_fifo
  import opcode_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [OPC_W-1:0]           i_data,
  input  logic                       i_pop,
  output logic [OPC_W-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [OPC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/opcode_issuer.sv
// Accepts 3-bit operations, encodes them to one-hot opcode words and queues them
// for the ALU front end; tracks issued opcodes and illegal requests.
module opcode_issuer
  import opcode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op_operation,
  output logic                   opc_valid,
  input  logic                   opc_ready,
  output logic [5:0]             opc_opcode,
  output logic                   illegal_seen,
  input  logic                   clear_err,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       issued_count
);

  logic             w_full;
  logic             w_empty;
  logic             w_up_xfer;
  logic             w_dn_xfer;
  logic             w_illegal;
  logic             w_push;
  logic [OPC_W-1:0] w_head;
  logic [OPC_W-1:0] w_enc;

  logic             r_illegal_seen;
  logic [CNT_W-1:0] r_issued_count;

  assign w_up_xfer = op_valid && !w_full;
  assign w_dn_xfer = opc_ready && !w_empty;
  assign w_illegal = (op_operation == OP_ILLEGAL);
  assign w_push    = w_up_xfer && !w_illegal;
  assign w_enc     = encode(op_operation);

  opcode_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_enc),
    .i_pop   (w_dn_xfer),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Set beats clear when an illegal transfer and clear_err coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_seen <= 1'b0;
      r_issued_count <= '0;
    end else begin
      if (w_up_xfer && w_illegal) begin
        r_illegal_seen <= 1'b1;
      end else if (clear_err) begin
        r_illegal_seen <= 1'b0;
      end
      if (w_dn_xfer) begin
        r_issued_count <= r_issued_count + 1'b1;
      end
    end
  end

  assign op_ready     = !w_full;
  assign opc_valid    = !w_empty;
  assign opc_opcode   = w_empty ? '0 : w_head;
  assign illegal_seen = r_illegal_seen;
  assign issued_count = r_issued_count;

endmodule
